// File: rtl/gnn_mac_sequencer_if.sv
// Bundle of the sequencer's control bus: frame handshake, MAC operand
// selects and strobes, result-write tags, and per-output ready flags.
//
// Handshake: in_ready is a level from the feature/weight source. A frame
// starts on a cycle where the sequencer is idle and armed and in_ready is
// high. In that cycle in_capture is high, and the datapath latches the
// x/w operands. After a frame, in_ready must be seen low before the
// sequencer accepts another start. A source that holds in_ready high
// therefore gets exactly one frame per level.
interface gnn_mac_sequencer_if #(
  parameter int N_NODES = 4,
  parameter int N_IN    = 4,
  parameter int N_HID   = 4,
  parameter int N_OUT   = 2
);
  localparam int NW   = (N_NODES > 1) ? $clog2(N_NODES) : 1;
  localparam int KMAX = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int KW   = (KMAX > 1) ? $clog2(KMAX) : 1;
  localparam int JMAX = (N_HID > N_OUT) ? N_HID : N_OUT;
  localparam int JW   = (JMAX > 1) ? $clog2(JMAX) : 1;

  logic                       in_ready;
  logic                       in_capture;
  logic                       busy;
  logic                       mac_clr;
  logic                       mac_en;
  logic                       layer;
  logic [NW-1:0]              sel_node;
  logic [KW-1:0]              sel_in;
  logic [JW-1:0]              sel_neu;
  logic                       res_wr;
  logic                       res_layer;
  logic [NW-1:0]              res_node;
  logic [JW-1:0]              res_idx;
  logic                       res_relu;
  logic [N_NODES*N_OUT-1:0]   out_ready;
  logic                       done;

  modport master (
    input  in_ready,
    output in_capture, busy, mac_clr, mac_en, layer,
    output sel_node, sel_in, sel_neu,
    output res_wr, res_layer, res_node, res_idx, res_relu,
    output out_ready, done
  );

  modport slave (
    output in_ready,
    input  in_capture, busy, mac_clr, mac_en, layer,
    input  sel_node, sel_in, sel_neu,
    input  res_wr, res_layer, res_node, res_idx, res_relu,
    input  out_ready, done
  );
endinterface

// File: rtl/gnn_mac_sequencer.sv
// Control FSM for a time-multiplexed two-layer GNN datapath that uses a
// single shared MAC. Layer 1 issues H = X*W1 term by term, and layer 2
// issues Y = H*W2. The term order has k fastest, then neuron j, then
// node n. Result-write tags travel down a MAC_LAT-deep pipeline.
// Optional feature macro: GNN_SEQ_RELU_EN. When it is defined, layer-1
// writes request ReLU. Otherwise res_relu is tied low.
module gnn_mac_sequencer #(
  parameter int N_NODES = 4,
  parameter int N_IN    = 4,
  parameter int N_HID   = 4,
  parameter int N_OUT   = 2,
  parameter int MAC_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gnn_mac_sequencer_if.master  bus,
  output logic [2:0]           dbg_state_o
);
  localparam int NW   = (N_NODES > 1) ? $clog2(N_NODES) : 1;
  localparam int KMAX = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int KW   = (KMAX > 1) ? $clog2(KMAX) : 1;
  localparam int JMAX = (N_HID > N_OUT) ? N_HID : N_OUT;
  localparam int JW   = (JMAX > 1) ? $clog2(JMAX) : 1;
  localparam int NR   = N_NODES * N_OUT;

  localparam logic [KW-1:0] K1_LAST = KW'(N_IN - 1);
  localparam logic [KW-1:0] K2_LAST = KW'(N_HID - 1);
  localparam logic [JW-1:0] J1_LAST = JW'(N_HID - 1);
  localparam logic [JW-1:0] J2_LAST = JW'(N_OUT - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(N_NODES - 1);
  localparam logic [4:0]    D_LAST  = 5'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_L1    = 3'd1,
    S_L2    = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            armed_q, armed_d;
  logic [KW-1:0]   k_q, k_d;
  logic [JW-1:0]   j_q, j_d;
  logic [NW-1:0]   n_q, n_d;
  logic [4:0]      drain_q, drain_d;
  logic            done_q, done_d;
  logic [NR-1:0]   ready_q, ready_d, set_mask;
  logic            issue, last_k, last_j, last_n, start;

  // Tag pipeline, one entry per MAC latency stage.
  logic            pv_q [MAC_LAT];
  logic            pl_q [MAC_LAT];
  logic [NW-1:0]   pn_q [MAC_LAT];
  logic [JW-1:0]   pj_q [MAC_LAT];

  // Term-position decode. Loop bounds depend on the active layer.
  always_comb begin
    issue  = (state_q == S_L1) || (state_q == S_L2);
    last_k = (state_q == S_L2) ? (k_q == K2_LAST) : (k_q == K1_LAST);
    last_j = (state_q == S_L2) ? (j_q == J2_LAST) : (j_q == J1_LAST);
    last_n = (n_q == N_LAST);
    // Gating with rst_n keeps in_capture low while reset is held.
    start  = (state_q == S_IDLE) && armed_q && bus.in_ready && rst_n;
  end

  // Next-state logic, term counters, drain timer and the arming latch.
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    k_d     = k_q;
    j_d     = j_q;
    n_d     = n_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_L1;
          armed_d = 1'b0;
          k_d     = '0;
          j_d     = '0;
          n_d     = '0;
        end
      end
      S_L1, S_L2: begin
        if (!last_k) begin
          k_d = k_q + 1'b1;
        end else begin
          k_d = '0;
          if (!last_j) begin
            j_d = j_q + 1'b1;
          end else begin
            j_d = '0;
            if (!last_n) begin
              n_d = n_q + 1'b1;
            end else begin
              n_d     = '0;
              drain_d = '0;
              state_d = (state_q == S_L1) ? S_L2 : S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == D_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!bus.in_ready) begin
          armed_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A layer-2 write marks its (node, neuron) result as valid. A new start clears all flags.
  always_comb begin
    set_mask = '0;
    for (int i = 0; i < NR; i++) begin
      set_mask[i] = bus.res_wr && bus.res_layer &&
                    (bus.res_node == NW'(i / N_OUT)) &&
                    (bus.res_idx == JW'(i % N_OUT));
    end
    ready_d = start ? '0 : (ready_q | set_mask);
  end

  // State, counter and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      armed_q <= 1'b1;
      k_q     <= '0;
      j_q     <= '0;
      n_q     <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
      ready_q <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      k_q     <= k_d;
      j_q     <= j_d;
      n_q     <= n_d;
      drain_q <= drain_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // Shift the last-term tags so res_wr lands MAC_LAT cycles after issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAC_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pl_q[i] <= 1'b0;
        pn_q[i] <= '0;
        pj_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= issue && last_k;
      pl_q[0] <= (state_q == S_L2);
      pn_q[0] <= n_q;
      pj_q[0] <= j_q;
      for (int i = 1; i < MAC_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pl_q[i] <= pl_q[i-1];
        pn_q[i] <= pn_q[i-1];
        pj_q[i] <= pj_q[i-1];
      end
    end
  end

  assign bus.in_capture = start;
  assign bus.busy       = issue || (state_q == S_DRAIN);
  assign bus.mac_en     = issue;
  assign bus.mac_clr    = issue && (k_q == '0);
  assign bus.layer      = (state_q == S_L2);
  assign bus.sel_node   = n_q;
  assign bus.sel_in     = k_q;
  assign bus.sel_neu    = j_q;
  assign bus.res_wr     = pv_q[MAC_LAT-1];
  assign bus.res_layer  = pv_q[MAC_LAT-1] && pl_q[MAC_LAT-1];
  assign bus.res_node   = pv_q[MAC_LAT-1] ? pn_q[MAC_LAT-1] : '0;
  assign bus.res_idx    = pv_q[MAC_LAT-1] ? pj_q[MAC_LAT-1] : '0;
`ifdef GNN_SEQ_RELU_EN
  assign bus.res_relu   = pv_q[MAC_LAT-1] && !pl_q[MAC_LAT-1];
`else
  assign bus.res_relu   = 1'b0;
`endif
  assign bus.out_ready  = ready_q;
  assign bus.done       = done_q;
  assign dbg_state_o    = state_q;
endmodule
